// File: rtl/fft_pipo_drain_pkg.sv
// -----------------------------------------------------------------------------
// fft_pipo_drain_pkg
// Shared types and constants for the PIPO read-side drain controller:
//   - state_e      : controller FSM states (IDLE, RUN, RELEASE)
//   - OUTBUF_DEPTH : number of entries in the output skid buffer
//   - OUTBUF_CNT_W : width of the output buffer occupancy counter
//   - clog2()      : ceiling log2 for elaboration-time sizing
// -----------------------------------------------------------------------------
package fft_pipo_drain_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam int OUTBUF_DEPTH = 32'sd2;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 32'sd0;
        v      = value - 32'sd1;
        while (v > 32'sd0) begin
            result = result + 32'sd1;
            v      = v >>> 32'sd1;
        end
        return result;
    endfunction

    // Occupancy must represent 0..OUTBUF_DEPTH.
    localparam int OUTBUF_CNT_W = clog2(OUTBUF_DEPTH + 32'sd1);

endpackage

// File: rtl/fft_pipo_drain_outbuf.sv
// -----------------------------------------------------------------------------
// fft_pipo_drain_outbuf
// Two-entry FIFO of {last, data} feeding the output stream. Entry 0 is always
// the head, so the head outputs come straight from registers and stay stable
// while the consumer stalls.
// Ports:
//   clk_i, rst_ni           : clock, synchronous active-low reset
//   push_i, push_data_i,
//   push_last_i             : write one word (ignored when full)
//   pop_i                   : remove head word (ignored when empty)
//   count_o                 : current occupancy (0..2)
//   valid_o                 : head entry present
//   head_data_o, head_last_o: head entry contents
// -----------------------------------------------------------------------------
module fft_pipo_drain_outbuf
    import fft_pipo_drain_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic [DataWidth-1:0]    push_data_i,
    input  logic                    push_last_i,
    input  logic                    pop_i,
    output logic [OUTBUF_CNT_W-1:0] count_o,
    output logic                    valid_o,
    output logic [DataWidth-1:0]    head_data_o,
    output logic                    head_last_o
);

    localparam logic [OUTBUF_CNT_W-1:0] CNT_FULL  = OUTBUF_CNT_W'(OUTBUF_DEPTH);
    localparam logic [OUTBUF_CNT_W-1:0] CNT_ONE   = OUTBUF_CNT_W'(1);
    localparam logic [OUTBUF_CNT_W-1:0] CNT_EMPTY = {OUTBUF_CNT_W{1'b0}};

    logic [DataWidth-1:0]    data0_q, data1_q;
    logic                    last0_q, last1_q;
    logic [OUTBUF_CNT_W-1:0] count_q;
    logic                    push_s;
    logic                    pop_s;

    // Guard push/pop so overflow or underflow can never corrupt the entries.
    always_comb begin
        push_s = push_i & (count_q != CNT_FULL);
        pop_s  = pop_i  & (count_q != CNT_EMPTY);
    end

    // Entry storage and occupancy; entry 1 shifts into entry 0 on pop.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data0_q <= {DataWidth{1'b0}};
            data1_q <= {DataWidth{1'b0}};
            last0_q <= 1'b0;
            last1_q <= 1'b0;
            count_q <= CNT_EMPTY;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_q == CNT_EMPTY) begin
                        data0_q <= push_data_i;
                        last0_q <= push_last_i;
                    end else begin
                        data1_q <= push_data_i;
                        last1_q <= push_last_i;
                    end
                    count_q <= count_q + CNT_ONE;
                end
                2'b01: begin
                    data0_q <= data1_q;
                    last0_q <= last1_q;
                    count_q <= count_q - CNT_ONE;
                end
                // Push is blocked when full and pop when empty, so a
                // simultaneous push/pop here always sees exactly one entry.
                2'b11: begin
                    data0_q <= push_data_i;
                    last0_q <= push_last_i;
                end
                default: begin
                    count_q <= count_q;
                end
            endcase
        end
    end

    assign count_o     = count_q;
    assign valid_o     = (count_q != CNT_EMPTY);
    assign head_data_o = data0_q;
    assign head_last_o = last0_q;

endmodule

// File: rtl/fft_pipo_drain.sv
// -----------------------------------------------------------------------------
// fft_pipo_drain
// Read-side controller for the FFT ping-pong channel. Waits for a full buffer,
// reads words 0..AddressRange-1 through the one-cycle-latency read port,
// streams them out (valid/ready with a last marker) and then releases the
// buffer with a single t_ce/t_read pulse.
// Ports:
//   clk, reset (sync, active-low)
//   t_empty_n                 : channel holds at least one full buffer
//   t_ce, t_read              : one-cycle buffer release pulse
//   t_ce0, t_address0, t_q0   : memory read port (data one cycle after t_ce0)
//   t_we0, t_d0               : write side, tied off
//   m_data, m_valid, m_last,
//   m_ready                   : output stream
//   busy                      : FSM active or output words pending
//   frame_count               : frames released, wraps
// -----------------------------------------------------------------------------
module fft_pipo_drain
    import fft_pipo_drain_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddressRange = 32,
    parameter int AddressWidth = 10,
    parameter int CountWidth   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    t_empty_n,
    output logic                    t_ce,
    output logic                    t_read,
    output logic                    t_ce0,
    output logic                    t_we0,
    output logic [AddressWidth-1:0] t_address0,
    output logic [DataWidth-1:0]    t_d0,
    input  logic [DataWidth-1:0]    t_q0,
    output logic [DataWidth-1:0]    m_data,
    output logic                    m_valid,
    output logic                    m_last,
    input  logic                    m_ready,
    output logic                    busy,
    output logic [CountWidth-1:0]   frame_count
);

    // One extra address bit so "all words issued" is representable.
    localparam int RA_W = AddressWidth + 32'sd1;
    localparam logic [RA_W-1:0] ADDR_END  = RA_W'(AddressRange);
    localparam logic [RA_W-1:0] ADDR_LAST = RA_W'(AddressRange - 32'sd1);
    localparam int CRED_W = OUTBUF_CNT_W + 32'sd1;

    state_e                  state_q;
    logic [RA_W-1:0]         rd_addr_q;
    logic                    inflight_q;
    logic                    inflight_last_q;
    logic [CountWidth-1:0]   frame_count_q;

    logic [OUTBUF_CNT_W-1:0] buf_count_s;
    logic                    buf_valid_s;
    logic [DataWidth-1:0]    head_data_s;
    logic                    head_last_s;
    logic                    pop_s;
    logic [CRED_W-1:0]       credit_s;
    logic                    issue_s;
    logic                    last_issue_s;

    // Read issue: the word being read now plus everything already held or in
    // flight must still fit in the output buffer after this cycle's pop.
    always_comb begin
        pop_s    = buf_valid_s & m_ready;
        credit_s = CRED_W'(buf_count_s) + CRED_W'(inflight_q) - CRED_W'(pop_s);
        if ((state_q == RUN) && (rd_addr_q < ADDR_END) && (credit_s <= CRED_W'(1))) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        last_issue_s = issue_s & (rd_addr_q == ADDR_LAST);
    end

    // Controller FSM, read address counter, in-flight tag and frame counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            rd_addr_q       <= {RA_W{1'b0}};
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            frame_count_q   <= {CountWidth{1'b0}};
        end else begin
            inflight_q      <= issue_s;
            inflight_last_q <= last_issue_s;
            if (issue_s) begin
                rd_addr_q <= rd_addr_q + RA_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (t_empty_n) begin
                        state_q   <= RUN;
                        rd_addr_q <= {RA_W{1'b0}};
                    end
                end
                RUN: begin
                    if (last_issue_s) begin
                        state_q <= RELEASE;
                    end
                end
                // t_empty_n is deliberately ignored here: the channel is
                // updating it at the same edge as the release pulse.
                RELEASE: begin
                    frame_count_q <= frame_count_q + CountWidth'(1);
                    state_q       <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Read data arrives one cycle after issue and is captured at that edge.
    fft_pipo_drain_outbuf #(
        .DataWidth (DataWidth)
    ) u_outbuf (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (inflight_q),
        .push_data_i (t_q0),
        .push_last_i (inflight_last_q),
        .pop_i       (pop_s),
        .count_o     (buf_count_s),
        .valid_o     (buf_valid_s),
        .head_data_o (head_data_s),
        .head_last_o (head_last_s)
    );

    assign t_ce0       = issue_s;
    assign t_address0  = rd_addr_q[AddressWidth-1:0];
    assign t_we0       = 1'b0;
    assign t_d0        = {DataWidth{1'b0}};
    assign t_ce        = (state_q == RELEASE);
    assign t_read      = (state_q == RELEASE);
    assign m_data      = head_data_s;
    assign m_valid     = buf_valid_s;
    assign m_last      = head_last_s;
    assign busy        = (state_q != IDLE) | buf_valid_s;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fft_pipo_drain.sv
module tb_fft_pipo_drain;

    localparam int DW = 32;
    localparam int AR = 32;
    localparam int AW = 10;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          t_empty_n;
    logic          t_ce, t_read, t_ce0, t_we0;
    logic [AW-1:0] t_address0;
    logic [DW-1:0] t_d0;
    logic [DW-1:0] t_q0 = '0;
    logic [DW-1:0] m_data;
    logic          m_valid, m_last;
    logic          m_ready = 1'b1;
    logic          busy;
    logic [CW-1:0] frame_count;

    int loads_total = 0;
    int pops_total  = 0;
    int ready_mode  = 0;
    int n_checks    = 0;
    int n_fail      = 0;
    int cyc         = 0;
    int outstanding = 0;
    int lasts_seen  = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    typedef struct packed { logic [DW-1:0] d; logic l; } exp_t;
    exp_t exp_q[$];

    fft_pipo_drain #(
        .DataWidth(DW), .AddressRange(AR), .AddressWidth(AW), .CountWidth(CW)
    ) dut (
        .clk(clk), .reset(reset), .t_empty_n(t_empty_n), .t_ce(t_ce), .t_read(t_read),
        .t_ce0(t_ce0), .t_we0(t_we0), .t_address0(t_address0), .t_d0(t_d0), .t_q0(t_q0),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Word contents of channel frame number seq at address addr.
    function automatic logic [DW-1:0] make_word(input int seq, input int addr);
        logic [31:0] s;
        logic [31:0] a;
        s = seq;
        a = addr;
        return {s[15:0], 16'h0100 + a[15:0]};
    endfunction

    // Channel model: frames queued by load_frame, popped on the release pulse.
    assign t_empty_n = (loads_total != pops_total);

    always @(posedge clk) begin
        if (t_ce && t_read) pops_total <= pops_total + 1;
        if (t_ce0) t_q0 <= make_word(pops_total, int'(t_address0));
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: m_ready = 1'b1;
            1: m_ready = ($urandom_range(1, 0) == 1);
            default: m_ready = 1'b0;
        endcase
    end

    task automatic push_frame(input int seq);
        exp_t e;
        for (int a = 0; a < AR; a++) begin
            e.d = make_word(seq, a);
            e.l = (a == AR - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic load_frame();
        push_frame(loads_total);
        loads_total = loads_total + 1;
    endtask

    task automatic rebuild_expected();
        exp_q.delete();
        for (int s = pops_total; s < loads_total; s++) push_frame(s);
    endtask

    // Advance to the next falling edge and run the stream scoreboard.
    task automatic tick();
        exp_t e;
        logic hs;
        @(negedge clk);
        cyc = cyc + 1;
        n_checks++;
        if (t_we0 !== 1'b0 || t_d0 !== '0) begin
            n_fail++;
            $display("FAIL tieoff: t_we0=%0b t_d0=%h required 0/0", t_we0, t_d0);
        end
        if (reset) begin
            hs = m_valid && m_ready;
            if (prev_stall) begin
                n_checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL hold: valid=%0b data=%h required 1/%h", m_valid, m_data, prev_data);
                end
            end
            if (hs) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_extra: got word %h, none expected", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e.d || m_last !== e.l) begin
                        n_fail++;
                        $display("FAIL sb_word: got %h/last=%0b required %h/last=%0b", m_data, m_last, e.d, e.l);
                    end
                end
                if (m_last) lasts_seen++;
            end
            n_checks++;
            if (outstanding > 2) begin
                n_fail++;
                $display("FAIL credit: outstanding=%0d required <=2", outstanding);
            end
            outstanding = outstanding + (t_ce0 ? 1 : 0) - (hs ? 1 : 0);
            prev_stall  = m_valid && !m_ready;
            prev_data   = m_data;
        end else begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_drain(input int limit, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || loads_total != pops_total) && n < limit) begin
            tick();
            n++;
        end
        n_checks++;
        if (n >= limit) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d words still expected after %0d cycles, required 0", name, exp_q.size(), limit);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({m_valid, m_last, t_ce, t_read, t_ce0, busy} !== 6'b0 || frame_count !== '0) begin
            n_fail++;
            $display("FAIL reset_state: v=%0b l=%0b ce=%0b rd=%0b ce0=%0b busy=%0b fc=%0d required all 0",
                     m_valid, m_last, t_ce, t_read, t_ce0, busy, frame_count);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_idle();
        do_reset();
        ready_mode = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_checks++;
            if ({t_ce0, t_ce, m_valid, busy} !== 4'b0) begin
                n_fail++;
                $display("FAIL idle: ce0=%0b ce=%0b valid=%0b busy=%0b required 0", t_ce0, t_ce, m_valid, busy);
            end
        end
    endtask

    task automatic test_single_frame();
        int p0, l0;
        logic exp_ce0, exp_val;
        logic [AW-1:0] ea;
        do_reset();
        ready_mode = 0;
        p0 = pops_total;
        l0 = lasts_seen;
        load_frame();
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) tick();
            exp_ce0 = (c >= 1 && c <= AR);
            exp_val = (c >= 3 && c <= AR + 2);
            ea = AW'(c - 1);
            n_checks++;
            if (t_ce0 !== exp_ce0 || (exp_ce0 && t_address0 !== ea)) begin
                n_fail++;
                $display("FAIL single_read c%0d: ce0=%0b addr=%0d required %0b/%0d", c, t_ce0, t_address0, exp_ce0, ea);
            end
            n_checks++;
            if (m_valid !== exp_val || (exp_val && m_last !== (c == AR + 2))) begin
                n_fail++;
                $display("FAIL single_stream c%0d: valid=%0b last=%0b required %0b/%0b", c, m_valid, m_last, exp_val, (c == AR + 2));
            end
            n_checks++;
            if (t_ce !== (c == AR + 1) || t_read !== (c == AR + 1)) begin
                n_fail++;
                $display("FAIL single_release c%0d: ce=%0b read=%0b required %0b", c, t_ce, t_read, (c == AR + 1));
            end
        end
        wait_drain(200, "single");
        n_checks++;
        if (frame_count !== CW'(1) || pops_total - p0 != 1 || lasts_seen - l0 != 1) begin
            n_fail++;
            $display("FAIL single_totals: fc=%0d releases=%0d lasts=%0d required 1/1/1", frame_count, pops_total - p0, lasts_seen - l0);
        end
    endtask

    task automatic test_back_to_back();
        int p0, l0, n_iss, c31, c32, n;
        logic [AW-1:0] ea;
        do_reset();
        ready_mode = 0;
        p0 = pops_total;
        l0 = lasts_seen;
        n_iss = 0; c31 = 0; c32 = 0; n = 0;
        load_frame();
        load_frame();
        while ((exp_q.size() != 0 || busy || loads_total != pops_total) && n < 400) begin
            tick();
            n++;
            if (t_ce0) begin
                ea = AW'(n_iss % AR);
                n_checks++;
                if (t_address0 !== ea) begin
                    n_fail++;
                    $display("FAIL b2b_addr: issue %0d addr=%0d required %0d", n_iss, t_address0, ea);
                end
                if (n_iss == AR - 1) c31 = cyc;
                if (n_iss == AR) c32 = cyc;
                n_iss++;
            end
        end
        n_checks++;
        if (n_iss != 2 * AR || c32 - c31 != 3) begin
            n_fail++;
            $display("FAIL b2b_gap: issues=%0d gap=%0d required %0d/3", n_iss, c32 - c31, 2 * AR);
        end
        n_checks++;
        if (frame_count !== CW'(2) || pops_total - p0 != 2 || lasts_seen - l0 != 2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_totals: fc=%0d releases=%0d lasts=%0d left=%0d required 2/2/2/0",
                     frame_count, pops_total - p0, lasts_seen - l0, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int seq, n;
        logic found;
        do_reset();
        ready_mode = 0;
        seq = loads_total;
        load_frame();
        found = 1'b0;
        n = 0;
        while (!found && n < 100) begin
            tick();
            n++;
            if (m_valid && m_ready && m_data === make_word(seq, 4)) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL bp_word4: word 4 not accepted within 100 cycles, required accepted");
        end
        ready_mode = 2;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== make_word(seq, 5) || t_ce0 !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall%0d: valid=%0b data=%h ce0=%0b required 1/%h/0", i, m_valid, m_data, t_ce0, make_word(seq, 5));
            end
        end
        ready_mode = 0;
        wait_drain(200, "bp");
        n_checks++;
        if (frame_count !== CW'(1)) begin
            n_fail++;
            $display("FAIL bp_count: fc=%0d required 1", frame_count);
        end
    endtask

    task automatic test_random();
        int p0, l0;
        do_reset();
        p0 = pops_total;
        l0 = lasts_seen;
        ready_mode = 1;
        for (int f = 0; f < 100; f++) load_frame();
        wait_drain(20000, "random");
        ready_mode = 0;
        n_checks++;
        if (frame_count !== CW'(100) || pops_total - p0 != 100 || lasts_seen - l0 != 100) begin
            n_fail++;
            $display("FAIL random_totals: fc=%0d releases=%0d lasts=%0d required 100/100/100",
                     frame_count, pops_total - p0, lasts_seen - l0);
        end
    endtask

    task automatic test_reset_mid();
        int seq, p0, n;
        logic found;
        do_reset();
        ready_mode = 0;
        p0 = pops_total;
        seq = loads_total;
        load_frame();
        found = 1'b0;
        n = 0;
        while (!found && n < 100) begin
            tick();
            n++;
            if (m_valid && m_ready && m_data === make_word(seq, 10)) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL mid_word10: word 10 not accepted within 100 cycles, required accepted");
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        rebuild_expected();
        tick();
        tick();
        n_checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || frame_count !== '0 || t_ce !== 1'b0 || pops_total != p0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%0b busy=%0b fc=%0d ce=%0b releases=%0d required 0/0/0/0/0",
                     m_valid, busy, frame_count, t_ce, pops_total - p0);
        end
        reset = 1'b1;
        n = 0;
        while (!t_ce0 && n < 20) begin
            tick();
            n++;
        end
        n_checks++;
        if (t_ce0 !== 1'b1 || t_address0 !== '0) begin
            n_fail++;
            $display("FAIL mid_restart: ce0=%0b addr=%0d required 1/0", t_ce0, t_address0);
        end
        wait_drain(200, "mid");
        n_checks++;
        if (frame_count !== CW'(1) || pops_total - p0 != 1) begin
            n_fail++;
            $display("FAIL mid_totals: fc=%0d releases=%0d required 1/1", frame_count, pops_total - p0);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
